// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array SRAM address sequencer:
//   - default channel count and SRAM address width
//   - FSM state encoding for sram_addr_gen
//   - lane_lsb(): bit offset of channel c inside a packed per-channel bus
// -----------------------------------------------------------------------------
package sa_pkg;

   localparam int NUM_CH_DEFAULT = 8;
   localparam int ADDR_W_DEFAULT = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Channel c occupies bits [c*addr_w +: addr_w] of a packed address bus.
   function automatic int lane_lsb(input int c, input int addr_w);
      return c * addr_w;
   endfunction

endpackage

// File: rtl/skew_lane.sv
// -----------------------------------------------------------------------------
// skew_lane
// Per-channel decode for sram_addr_gen. Channel C trails channel 0 by C cycles,
// so it is live while C <= t < C + num_steps_q and reads (base + t - C).
// Ports:
//   run          - sequencer is in RUN; outputs are zero otherwise
//   t            - shared run-time counter
//   num_steps_q  - latched addresses-per-channel
//   w_base_q     - latched weight base address
//   d_base_q     - latched data base address
//   rvalid       - read enable for this channel
//   w_addr       - weight read address (0 when inactive)
//   d_addr       - data read address (0 when inactive)
// -----------------------------------------------------------------------------
module skew_lane
   import sa_pkg::*;
#(
   parameter int C      = 0,
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int STEP_W = 7,
   parameter int T_W    = STEP_W + 1
) (
   input  logic              run,
   input  logic [T_W-1:0]    t,
   input  logic [STEP_W-1:0] num_steps_q,
   input  logic [ADDR_W-1:0] w_base_q,
   input  logic [ADDR_W-1:0] d_base_q,
   output logic              rvalid,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] d_addr
);

   // One extra bit so C + num_steps_q can never wrap during the window test.
   localparam logic [T_W:0] LANE_START = (T_W+1)'(C);

   logic [T_W:0] lane_end;
   logic         active;

   assign lane_end = LANE_START + (T_W+1)'(num_steps_q);
   assign active   = run && ({1'b0, t} >= LANE_START) && ({1'b0, t} < lane_end);

   // t >= C whenever the lane is active, so t - C is a true non-negative
   // offset; adding it in ADDR_W bits gives the intended silent wrap.
   always_comb begin
      rvalid = 1'b0;
      w_addr = '0;
      d_addr = '0;
      if (active) begin
         rvalid = 1'b1;
         w_addr = w_base_q + ADDR_W'(t - T_W'(C));
         d_addr = d_base_q + ADDR_W'(t - T_W'(C));
      end
   end

endmodule

// File: rtl/sram_addr_gen.sv
// -----------------------------------------------------------------------------
// sram_addr_gen
// Read-address sequencer for the systolic array's weight and data SRAM banks.
// A start pulse latches two base addresses and a step count; the block then
// walks a time counter t and emits diagonally skewed per-channel addresses
// (channel c lags channel 0 by c cycles), finishing with a one-cycle done.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - run request, honoured only in IDLE or DONE
//   w_base        - weight base address, latched on accepted start
//   d_base        - data base address, latched on accepted start
//   num_steps     - addresses per channel, latched on accepted start
//   stall         - freezes t and all outputs while in RUN
//   busy          - high for every RUN cycle
//   done          - one-cycle completion pulse
//   rvalid        - per-channel read enable
//   sram_raddr_w  - packed weight read addresses, channel c at [c*ADDR_W +: ADDR_W]
//   sram_raddr_d  - packed data read addresses, same packing
// -----------------------------------------------------------------------------
module sram_addr_gen
   import sa_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int STEP_W = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        w_base,
   input  logic [ADDR_W-1:0]        d_base,
   input  logic [STEP_W-1:0]        num_steps,
   input  logic                     stall,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_CH-1:0]        rvalid,
   output logic [NUM_CH*ADDR_W-1:0] sram_raddr_w,
   output logic [NUM_CH*ADDR_W-1:0] sram_raddr_d
);

   // Wide enough for num_steps + NUM_CH - 2 at its largest, with margin.
   localparam int T_W = STEP_W + $clog2(NUM_CH) + 1;

   state_t            state;
   logic [T_W-1:0]    t;
   logic [T_W-1:0]    last_t;
   logic [ADDR_W-1:0] w_base_q;
   logic [ADDR_W-1:0] d_base_q;
   logic [STEP_W-1:0] num_steps_q;
   logic              run;

   // Final RUN cycle: the last channel issues its last address at
   // t = (NUM_CH-1) + (num_steps-1). num_steps_q is nonzero in RUN.
   assign last_t = T_W'(num_steps_q) + T_W'(NUM_CH) - T_W'(2);
   assign run    = (state == RUN);

   // Sequencer FSM. DONE accepts start exactly like IDLE so runs can be
   // chained without a bubble; a zero-length request goes straight to DONE.
   // A stalled RUN cycle makes no assignment, so every register holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         t           <= '0;
         w_base_q    <= '0;
         d_base_q    <= '0;
         num_steps_q <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  w_base_q    <= w_base;
                  d_base_q    <= d_base;
                  num_steps_q <= num_steps;
                  t           <= '0;
                  if (num_steps != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (t == last_t) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     t <= t + T_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // One decode lane per channel, each knowing its own skew C.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      logic              lane_rvalid;
      logic [ADDR_W-1:0] lane_w_addr;
      logic [ADDR_W-1:0] lane_d_addr;

      skew_lane #(
         .C      (c),
         .ADDR_W (ADDR_W),
         .STEP_W (STEP_W),
         .T_W    (T_W)
      ) u_lane (
         .run         (run),
         .t           (t),
         .num_steps_q (num_steps_q),
         .w_base_q    (w_base_q),
         .d_base_q    (d_base_q),
         .rvalid      (lane_rvalid),
         .w_addr      (lane_w_addr),
         .d_addr      (lane_d_addr)
      );

      assign rvalid[c]                                     = lane_rvalid;
      assign sram_raddr_w[lane_lsb(c, ADDR_W) +: ADDR_W]   = lane_w_addr;
      assign sram_raddr_d[lane_lsb(c, ADDR_W) +: ADDR_W]   = lane_d_addr;
   end

endmodule

// File: tb/tb_sram_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_sram_addr_gen
// Self-checking bench for sram_addr_gen. Three instances share the clock and
// reset: an 8-channel/10-bit main instance driven by directed steps, and
// 1-channel and 16-channel 12-bit instances driven by random runs. A
// behavioural model of each instance advances on every rising edge and pushes
// its expected outputs into a queue; they are popped and compared 1ns later.
// -----------------------------------------------------------------------------
module tb_sram_addr_gen;

   logic clk = 1'b0;
   logic rst;

   // Main instance stimulus and outputs
   logic        start;
   logic [9:0]  w_base;
   logic [9:0]  d_base;
   logic [6:0]  num_steps;
   logic        stall;
   logic        busy;
   logic        done;
   logic [7:0]  rvalid;
   logic [79:0] addr_w;
   logic [79:0] addr_d;

   // Sweep instances share one stimulus set
   logic         s_start;
   logic [11:0]  s_w_base;
   logic [11:0]  s_d_base;
   logic [6:0]   s_num_steps;
   logic         s_stall;
   logic         s1_busy, s1_done;
   logic [0:0]   s1_rvalid;
   logic [11:0]  s1_addr_w, s1_addr_d;
   logic         s16_busy, s16_done;
   logic [15:0]  s16_rvalid;
   logic [191:0] s16_addr_w, s16_addr_d;

   always #5 clk = ~clk;

   sram_addr_gen #(.NUM_CH(8), .ADDR_W(10), .STEP_W(7)) u_dut (
      .clk(clk), .rst(rst), .start(start), .w_base(w_base), .d_base(d_base),
      .num_steps(num_steps), .stall(stall), .busy(busy), .done(done),
      .rvalid(rvalid), .sram_raddr_w(addr_w), .sram_raddr_d(addr_d)
   );

   sram_addr_gen #(.NUM_CH(1), .ADDR_W(12), .STEP_W(7)) u_dut1 (
      .clk(clk), .rst(rst), .start(s_start), .w_base(s_w_base), .d_base(s_d_base),
      .num_steps(s_num_steps), .stall(s_stall), .busy(s1_busy), .done(s1_done),
      .rvalid(s1_rvalid), .sram_raddr_w(s1_addr_w), .sram_raddr_d(s1_addr_d)
   );

   sram_addr_gen #(.NUM_CH(16), .ADDR_W(12), .STEP_W(7)) u_dut16 (
      .clk(clk), .rst(rst), .start(s_start), .w_base(s_w_base), .d_base(s_d_base),
      .num_steps(s_num_steps), .stall(s_stall), .busy(s16_busy), .done(s16_done),
      .rvalid(s16_rvalid), .sram_raddr_w(s16_addr_w), .sram_raddr_d(s16_addr_d)
   );

   // Behavioural model state: st 0=IDLE 1=RUN 2=DONE
   typedef struct {
      int st;
      int t;
      int wb;
      int db;
      int ns;
   } mdl_t;

   typedef struct {
      logic         busy;
      logic         done;
      logic [191:0] rv;
      logic [191:0] wa;
      logic [191:0] da;
   } exp_t;

   mdl_t m_main, m_s1, m_s16;
   exp_t q_main[$], q_s1[$], q_s16[$];

   int vectors     = 0;
   int miscompares = 0;

   // Per-run trackers for the main instance
   int cyc;
   int done_cyc;
   int busy_cnt;
   int ch7_first;
   int ch7_last;
   int ch0_w[$];
   int ch0_d[$];
   logic rv_seen;
   logic s1_done_seen, s16_done_seen;

   // Next model state from the current state and inputs sampled at the edge
   function automatic mdl_t mdl_next(mdl_t m, logic r, logic s, int wb, int db,
                                     int ns, logic stl, int nc);
      mdl_t n;
      n = m;
      if (r) begin
         n.st = 0; n.t = 0; n.wb = 0; n.db = 0; n.ns = 0;
      end else if (m.st == 1) begin
         if (!stl) begin
            if (m.t == m.ns + nc - 2) n.st = 2;
            else                      n.t  = m.t + 1;
         end
      end else if (s) begin
         n.wb = wb; n.db = db; n.ns = ns; n.t = 0;
         n.st = (ns != 0) ? 1 : 2;
      end else begin
         n.st = 0;
      end
      return n;
   endfunction

   // Expected outputs straight from the channel formula
   function automatic exp_t mdl_out(mdl_t m, int nc, int aw);
      exp_t e;
      int   a;
      e.busy = (m.st == 1);
      e.done = (m.st == 2);
      e.rv   = '0;
      e.wa   = '0;
      e.da   = '0;
      if (m.st == 1) begin
         for (int c = 0; c < nc; c++) begin
            if (m.t >= c && m.t < c + m.ns) begin
               e.rv[c] = 1'b1;
               a = (m.wb + m.t - c) % (1 << aw);
               for (int b = 0; b < aw; b++) e.wa[c*aw + b] = a[b];
               a = (m.db + m.t - c) % (1 << aw);
               for (int b = 0; b < aw; b++) e.da[c*aw + b] = a[b];
            end
         end
      end
      return e;
   endfunction

   task automatic check_output(input string tag, input logic [191:0] obs,
                               input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: advance models at the edge, queue expectations, then compare
   task automatic apply_stimulus();
      exp_t e;
      @(posedge clk);
      m_main = mdl_next(m_main, rst, start, int'(w_base), int'(d_base),
                        int'(num_steps), stall, 8);
      m_s1   = mdl_next(m_s1, rst, s_start, int'(s_w_base), int'(s_d_base),
                        int'(s_num_steps), s_stall, 1);
      m_s16  = mdl_next(m_s16, rst, s_start, int'(s_w_base), int'(s_d_base),
                        int'(s_num_steps), s_stall, 16);
      q_main.push_back(mdl_out(m_main, 8, 10));
      q_s1.push_back(mdl_out(m_s1, 1, 12));
      q_s16.push_back(mdl_out(m_s16, 16, 12));
      #1;
      cyc++;

      e = q_main.pop_front();
      check_output("main_busy",   192'(busy),   192'(e.busy));
      check_output("main_done",   192'(done),   192'(e.done));
      check_output("main_rvalid", 192'(rvalid), e.rv);
      check_output("main_addr_w", 192'(addr_w), e.wa);
      check_output("main_addr_d", 192'(addr_d), e.da);

      e = q_s1.pop_front();
      check_output("s1_busy",   192'(s1_busy),   192'(e.busy));
      check_output("s1_done",   192'(s1_done),   192'(e.done));
      check_output("s1_rvalid", 192'(s1_rvalid), e.rv);
      check_output("s1_addr_w", 192'(s1_addr_w), e.wa);
      check_output("s1_addr_d", 192'(s1_addr_d), e.da);

      e = q_s16.pop_front();
      check_output("s16_busy",   192'(s16_busy),   192'(e.busy));
      check_output("s16_done",   192'(s16_done),   192'(e.done));
      check_output("s16_rvalid", 192'(s16_rvalid), e.rv);
      check_output("s16_addr_w", s16_addr_w,       e.wa);
      check_output("s16_addr_d", s16_addr_d,       e.da);

      if (done && done_cyc < 0) done_cyc = cyc;
      if (busy) busy_cnt++;
      if (rvalid[0]) begin
         ch0_w.push_back(int'(addr_w[9:0]));
         ch0_d.push_back(int'(addr_d[9:0]));
      end
      if (rvalid[7]) begin
         if (ch7_first < 0) ch7_first = cyc;
         ch7_last = cyc;
      end
      rv_seen       = rv_seen | (|rvalid);
      s1_done_seen  = s1_done_seen | s1_done;
      s16_done_seen = s16_done_seen | s16_done;
   endtask

   task automatic begin_run();
      cyc       = 0;
      done_cyc  = -1;
      busy_cnt  = 0;
      ch7_first = -1;
      ch7_last  = -1;
      rv_seen   = 1'b0;
      ch0_w.delete();
      ch0_d.delete();
   endtask

   // Accepted-start edge; on return the sample shows cycle 1 (t = 0)
   task automatic launch(input int wb, input int db, input int ns);
      begin_run();
      start     = 1'b1;
      w_base    = 10'(wb);
      d_base    = 10'(db);
      num_steps = 7'(ns);
      apply_stimulus();
      start     = 1'b0;
   endtask

   task automatic run_until_done(input string tag, input int limit);
      int i;
      i = 0;
      while (done_cyc < 0 && i < limit) begin
         apply_stimulus();
         i++;
      end
      check_int({tag, "_done_in_bound"}, int'(done_cyc >= 0), 1);
   endtask

   task automatic check_ch0(input string tag, input int wb, input int db, input int n);
      check_int({tag, "_ch0_count"}, ch0_w.size(), n);
      if (ch0_w.size() == n) begin
         for (int k = 0; k < n; k++) begin
            check_int($sformatf("%s_ch0_w%0d", tag, k), ch0_w[k], (wb + k) % 1024);
            check_int($sformatf("%s_ch0_d%0d", tag, k), ch0_d[k], (db + k) % 1024);
         end
      end
   endtask

   initial begin
      int i;
      m_main = '{0, 0, 0, 0, 0};
      m_s1   = '{0, 0, 0, 0, 0};
      m_s16  = '{0, 0, 0, 0, 0};
      rst = 1'b1; start = 1'b0; w_base = '0; d_base = '0; num_steps = '0; stall = 1'b0;
      s_start = 1'b0; s_w_base = '0; s_d_base = '0; s_num_steps = '0; s_stall = 1'b0;
      begin_run();

      // Reset state
      $display("[TB] reset");
      apply_stimulus();
      apply_stimulus();
      check_output("reset_busy",   192'(busy),   '0);
      check_output("reset_done",   192'(done),   '0);
      check_output("reset_rvalid", 192'(rvalid), '0);
      check_output("reset_addr_w", 192'(addr_w), '0);
      rst = 1'b0;
      apply_stimulus();

      // Basic run: w_base=0, d_base=100, num_steps=4
      $display("[TB] basic run");
      launch(0, 100, 4);
      run_until_done("basic", 20);
      check_int("basic_done_cycle", done_cyc, 12);
      check_int("basic_busy_cycles", busy_cnt, 11);
      check_int("basic_ch7_first", ch7_first, 8);
      check_int("basic_ch7_last", ch7_last, 11);
      check_ch0("basic", 0, 100, 4);
      apply_stimulus();

      // Address wrap at the top of the 10-bit space
      $display("[TB] wrap");
      launch(1022, 1020, 4);
      run_until_done("wrap", 20);
      check_ch0("wrap", 1022, 1020, 4);
      check_int("wrap_ch0_w2_is_zero", (ch0_w.size() == 4) ? ch0_w[2] : -1, 0);
      apply_stimulus();

      // Two stall cycles while t = 2
      $display("[TB] stall");
      launch(0, 100, 4);
      apply_stimulus();
      apply_stimulus();
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         apply_stimulus();
         check_output("stall_rvalid", 192'(rvalid), 192'(8'b0000_0111));
         check_int("stall_ch0_w", int'(addr_w[9:0]),   2);
         check_int("stall_ch1_w", int'(addr_w[19:10]), 1);
         check_int("stall_ch2_w", int'(addr_w[29:20]), 0);
         check_int("stall_ch0_d", int'(addr_d[9:0]),   102);
         check_int("stall_busy",  int'(busy),          1);
      end
      stall = 1'b0;
      run_until_done("stall", 20);
      check_int("stall_done_cycle", done_cyc, 14);
      check_int("stall_busy_cycles", busy_cnt, 13);
      apply_stimulus();

      // Zero-length request
      $display("[TB] num_steps=0");
      launch(3, 4, 0);
      check_int("zero_done_cycle", done_cyc, 1);
      apply_stimulus();
      apply_stimulus();
      check_int("zero_busy_cycles", busy_cnt, 0);
      check_int("zero_rvalid_seen", int'(rv_seen), 0);

      // Start while running is ignored
      $display("[TB] start in RUN");
      launch(0, 100, 4);
      apply_stimulus();
      start = 1'b1; w_base = 10'd500; d_base = 10'd600; num_steps = 7'd9;
      apply_stimulus();
      start = 1'b0;
      run_until_done("ignore", 20);
      check_int("ignore_done_cycle", done_cyc, 12);
      check_ch0("ignore", 0, 100, 4);
      apply_stimulus();

      // Start in the DONE cycle chains the next run with no bubble
      $display("[TB] start in DONE");
      launch(0, 100, 4);
      run_until_done("chain_a", 20);
      begin_run();
      start = 1'b1; w_base = 10'd200; d_base = 10'd300; num_steps = 7'd2;
      apply_stimulus();
      start = 1'b0;
      check_int("chain_rvalid0", int'(rvalid[0]), 1);
      check_int("chain_ch0_w",   int'(addr_w[9:0]), 200);
      check_int("chain_busy",    int'(busy), 1);
      run_until_done("chain_b", 20);
      check_int("chain_done_cycle", done_cyc, 10);
      apply_stimulus();

      // Reset mid-run at t = 5
      $display("[TB] reset mid-run");
      launch(0, 100, 4);
      repeat (5) apply_stimulus();
      rst = 1'b1;
      apply_stimulus();
      rst = 1'b0;
      check_output("midrst_busy",   192'(busy),   '0);
      check_output("midrst_done",   192'(done),   '0);
      check_output("midrst_rvalid", 192'(rvalid), '0);
      check_output("midrst_addr_d", 192'(addr_d), '0);
      apply_stimulus();
      check_int("midrst_no_done", int'(done), 0);
      launch(7, 9, 3);
      run_until_done("after_rst", 20);
      check_int("after_rst_done_cycle", done_cyc, 11);
      apply_stimulus();

      // Random sweep on the 1- and 16-channel, 12-bit instances
      $display("[TB] parameter sweep");
      for (int r = 0; r < 12; r++) begin
         s_w_base = 12'($urandom_range(0, 4095));
         s_d_base = 12'($urandom_range(0, 4095));
         if (r == 0)      s_num_steps = 7'd127;
         else if (r == 1) s_num_steps = 7'd0;
         else if (r == 2) s_num_steps = 7'd1;
         else             s_num_steps = 7'($urandom_range(1, 30));
         s1_done_seen  = 1'b0;
         s16_done_seen = 1'b0;
         s_start = 1'b1;
         apply_stimulus();
         s_start = 1'b0;
         i = 0;
         while (!(s1_done_seen && s16_done_seen) && i < 400) begin
            s_stall = ($urandom_range(0, 3) == 0);
            apply_stimulus();
            i++;
         end
         s_stall = 1'b0;
         check_int("sweep_done_in_bound", int'(s1_done_seen && s16_done_seen), 1);
         apply_stimulus();
         apply_stimulus();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
